// File: rtl/testchip_rst_seq_pkg.sv
// Shared types and constants for the testchip reset sequencer.
// Domain indices fix both the release order (ascending) and the assert order (descending).
package testchip_rst_seq_pkg;

    localparam int NUM_DOM   = 4;

    localparam int DOM_TCLK  = 0;
    localparam int DOM_DDRIO = 1;
    localparam int DOM_PHY   = 2;
    localparam int DOM_PAM3  = 3;

    typedef logic [NUM_DOM-1:0] dom_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        UP      = 2'd2,
        RAMP_DN = 2'd3
    } seq_state_e;

endpackage : testchip_rst_seq_pkg

// File: rtl/testchip_rst_gap_cnt.sv
// Loadable down-counter that spaces the sequencer steps.
// It saturates at zero, so an idle counter never wraps back to the top of its range.
module testchip_rst_gap_cnt #(
    parameter int DLY_W = 8
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    output logic             zero
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : testchip_rst_gap_cnt

// File: rtl/testchip_rst_seq.sv
// Programmable reset sequencer: releases the four clock/reset-block domains in ascending
// order with a programmable gap, asserts them again in descending order, reports progress.
module testchip_rst_seq
    import testchip_rst_seq_pkg::*;
#(
    parameter int DLY_W = 8
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    input  logic             seq_up_req,
    input  logic             seq_dn_req,
    input  logic [3:0]       dom_mask,
    input  logic [DLY_W-1:0] gap_cycles,
    output logic             param_test_clk_ctrl_reset_n,
    output logic             param_ddrio_ctrl_reset_n,
    output logic             param_phy_ss_reset_n,
    output logic             param_pam3_ss_reset_n,
    output logic             seq_busy,
    output logic             seq_up_done,
    output logic             seq_err
);

    seq_state_e       state_q, state_d;
    dom_vec_t         rel_q, rel_d;
    dom_vec_t         mask_q, mask_d;
    logic [DLY_W-1:0] gap_q, gap_d;
    logic             busy_q, busy_d;
    logic             up_done_q, up_done_d;
    logic             err_q, err_d;

    dom_vec_t         up_cand;
    dom_vec_t         up_sel;
    dom_vec_t         dn_sel;
    dom_vec_t         rel_dn;
    logic             step_load;
    logic             gap_zero;

    testchip_rst_gap_cnt #(
        .DLY_W (DLY_W)
    ) u_gap_cnt (
        .noc_clk  (noc_clk),
        .noc_rst  (noc_rst),
        .load     (step_load),
        .load_val (gap_d),
        .zero     (gap_zero)
    );

    // Priority encoders: lowest domain still waiting to be released, highest domain released.
    always_comb begin
        up_cand = (state_q == IDLE) ? dom_vec_t'(dom_mask) : (mask_q & ~rel_q);
        up_sel  = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (up_cand[i]) begin
                up_sel    = '0;
                up_sel[i] = 1'b1;
            end
        end
        dn_sel = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (rel_q[i]) begin
                dn_sel    = '0;
                dn_sel[i] = 1'b1;
            end
        end
        rel_dn = rel_q & ~dn_sel;
    end

    always_comb begin
        state_d   = state_q;
        rel_d     = rel_q;
        mask_d    = mask_q;
        gap_d     = gap_q;
        up_done_d = up_done_q;
        err_d     = 1'b0;
        step_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A simultaneous down request wins, and down from IDLE is a no-op.
                if (seq_up_req && !seq_dn_req) begin
                    mask_d    = dom_vec_t'(dom_mask);
                    gap_d     = gap_cycles;
                    rel_d     = up_sel;
                    step_load = 1'b1;
                    if ((up_cand & ~up_sel) == '0) begin
                        state_d   = UP;
                        up_done_d = 1'b1;
                    end else begin
                        state_d   = RAMP_UP;
                    end
                end
            end

            RAMP_UP: begin
                if (seq_dn_req) begin
                    rel_d     = rel_dn;
                    step_load = 1'b1;
                    state_d   = (rel_dn == '0) ? IDLE : RAMP_DN;
                end else if (gap_zero) begin
                    rel_d     = rel_q | up_sel;
                    step_load = 1'b1;
                    if ((up_cand & ~up_sel) == '0) begin
                        state_d   = UP;
                        up_done_d = 1'b1;
                    end
                end
            end

            UP: begin
                if (seq_dn_req) begin
                    rel_d     = rel_dn;
                    up_done_d = 1'b0;
                    step_load = 1'b1;
                    state_d   = (rel_dn == '0) ? IDLE : RAMP_DN;
                end
            end

            RAMP_DN: begin
                err_d = seq_up_req;
                if (gap_zero) begin
                    rel_d     = rel_dn;
                    step_load = 1'b1;
                    if (rel_dn == '0) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DN);
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q   <= IDLE;
            rel_q     <= '0;
            mask_q    <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            up_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rel_q     <= rel_d;
            mask_q    <= mask_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            up_done_q <= up_done_d;
            err_q     <= err_d;
        end
    end

    assign param_test_clk_ctrl_reset_n = rel_q[DOM_TCLK];
    assign param_ddrio_ctrl_reset_n    = rel_q[DOM_DDRIO];
    assign param_phy_ss_reset_n        = rel_q[DOM_PHY];
    assign param_pam3_ss_reset_n       = rel_q[DOM_PAM3];
    assign seq_busy                    = busy_q;
    assign seq_up_done                 = up_done_q;
    assign seq_err                     = err_q;

endmodule : testchip_rst_seq

// File: tb/tb_testchip_rst_seq.sv
// Directed bench for testchip_rst_seq: cycle-exact expectations for ramps, aborts, conflicts and reset.
module tb_testchip_rst_seq;

    localparam int DLY_W = 8;

    logic             clk = 1'b0;
    logic             noc_rst;
    logic             seq_up_req;
    logic             seq_dn_req;
    logic [3:0]       dom_mask;
    logic [DLY_W-1:0] gap_cycles;
    logic             tclk_n, ddrio_n, phy_n, pam3_n;
    logic             seq_busy, seq_up_done, seq_err;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    string test_name = "reset";

    testchip_rst_seq #(
        .DLY_W (DLY_W)
    ) dut (
        .noc_clk                     (clk),
        .noc_rst                     (noc_rst),
        .seq_up_req                  (seq_up_req),
        .seq_dn_req                  (seq_dn_req),
        .dom_mask                    (dom_mask),
        .gap_cycles                  (gap_cycles),
        .param_test_clk_ctrl_reset_n (tclk_n),
        .param_ddrio_ctrl_reset_n    (ddrio_n),
        .param_phy_ss_reset_n        (phy_n),
        .param_pam3_ss_reset_n       (pam3_n),
        .seq_busy                    (seq_busy),
        .seq_up_done                 (seq_up_done),
        .seq_err                     (seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled there too, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Request sampled at edge 0; on return the bench is in cycle 1.
    task automatic start(input string name, input logic up, input logic dn);
        test_name  = name;
        seq_up_req = up;
        seq_dn_req = dn;
        cyc        = 0;
        tick();
        seq_up_req = 1'b0;
        seq_dn_req = 1'b0;
    endtask

    task automatic check_at(input int c, input logic [3:0] rel, input logic busy,
                            input logic done, input logic err);
        run_to(c);
        check($sformatf("%s c%0d rel", test_name, c), {28'd0, pam3_n, phy_n, ddrio_n, tclk_n}, {28'd0, rel});
        check($sformatf("%s c%0d busy", test_name, c), {31'd0, seq_busy}, {31'd0, busy});
        check($sformatf("%s c%0d done", test_name, c), {31'd0, seq_up_done}, {31'd0, done});
        check($sformatf("%s c%0d err", test_name, c), {31'd0, seq_err}, {31'd0, err});
    endtask

    task automatic do_reset();
        noc_rst = 1'b1;
        tick();
        tick();
        noc_rst = 1'b0;
    endtask

    initial begin
        noc_rst    = 1'b1;
        seq_up_req = 1'b0;
        seq_dn_req = 1'b0;
        dom_mask   = 4'b1111;
        gap_cycles = 8'd3;
        do_reset();
        cyc = 0;
        check_at(0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Full release, gap 3: steps in cycles 1, 5, 9, 13.
        start("full_up", 1'b1, 1'b0);
        check_at(1,  4'h1, 1'b1, 1'b0, 1'b0);
        check_at(4,  4'h1, 1'b1, 1'b0, 1'b0);
        check_at(5,  4'h3, 1'b1, 1'b0, 1'b0);
        check_at(9,  4'h7, 1'b1, 1'b0, 1'b0);
        check_at(12, 4'h7, 1'b1, 1'b0, 1'b0);
        check_at(13, 4'hF, 1'b0, 1'b1, 1'b0);
        check_at(16, 4'hF, 1'b0, 1'b1, 1'b0);

        // Down from UP, reverse order with the same spacing.
        start("full_dn", 1'b0, 1'b1);
        check_at(1,  4'h7, 1'b1, 1'b0, 1'b0);
        check_at(5,  4'h3, 1'b1, 1'b0, 1'b0);
        check_at(9,  4'h1, 1'b1, 1'b0, 1'b0);
        check_at(13, 4'h0, 1'b0, 1'b0, 1'b0);

        // Masked release 1010, gap 0.
        dom_mask   = 4'b1010;
        gap_cycles = 8'd0;
        start("mask_up", 1'b1, 1'b0);
        check_at(1, 4'h2, 1'b1, 1'b0, 1'b0);
        check_at(2, 4'hA, 1'b0, 1'b1, 1'b0);
        start("up_in_up", 1'b1, 1'b0);
        check_at(1, 4'hA, 1'b0, 1'b1, 1'b0);
        start("mask_dn", 1'b0, 1'b1);
        check_at(1, 4'h2, 1'b1, 1'b0, 1'b0);
        check_at(2, 4'h0, 1'b0, 1'b0, 1'b0);
        start("dn_in_idle", 1'b0, 1'b1);
        check_at(1, 4'h0, 1'b0, 1'b0, 1'b0);
        check_at(3, 4'h0, 1'b0, 1'b0, 1'b0);

        // Abort: gap 5, dn_req sampled at edge 8 with domains 0 and 1 released.
        dom_mask   = 4'b1111;
        gap_cycles = 8'd5;
        start("abort", 1'b1, 1'b0);
        check_at(7, 4'h3, 1'b1, 1'b0, 1'b0);
        run_to(8);
        seq_dn_req = 1'b1;
        tick();
        seq_dn_req = 1'b0;
        check_at(9,  4'h1, 1'b1, 1'b0, 1'b0);
        check_at(14, 4'h1, 1'b1, 1'b0, 1'b0);
        check_at(15, 4'h0, 1'b0, 1'b0, 1'b0);

        // up_req during RAMP_DN is rejected with a one-cycle error pulse.
        gap_cycles = 8'd1;
        start("conf_up", 1'b1, 1'b0);
        check_at(7, 4'hF, 1'b0, 1'b1, 1'b0);
        start("conf_dn", 1'b0, 1'b1);
        check_at(1, 4'h7, 1'b1, 1'b0, 1'b0);
        run_to(2);
        seq_up_req = 1'b1;
        tick();
        seq_up_req = 1'b0;
        check_at(3, 4'h3, 1'b1, 1'b0, 1'b1);
        check_at(4, 4'h3, 1'b1, 1'b0, 1'b0);
        check_at(5, 4'h1, 1'b1, 1'b0, 1'b0);
        check_at(7, 4'h0, 1'b0, 1'b0, 1'b0);

        // Simultaneous up and down in UP: down ramp, no error.
        start("both_prep", 1'b1, 1'b0);
        check_at(7, 4'hF, 1'b0, 1'b1, 1'b0);
        start("both_in_up", 1'b1, 1'b1);
        check_at(1, 4'h7, 1'b1, 1'b0, 1'b0);
        check_at(7, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset mid-ramp, then a clean restart from domain 0.
        gap_cycles = 8'd3;
        start("rst_mid", 1'b1, 1'b0);
        check_at(5, 4'h3, 1'b1, 1'b0, 1'b0);
        run_to(6);
        noc_rst = 1'b1;
        tick();
        noc_rst = 1'b0;
        check_at(7, 4'h0, 1'b0, 1'b0, 1'b0);
        start("rst_restart", 1'b1, 1'b0);
        check_at(1, 4'h1, 1'b1, 1'b0, 1'b0);
        check_at(4, 4'h1, 1'b1, 1'b0, 1'b0);
        check_at(5, 4'h3, 1'b1, 1'b0, 1'b0);
        do_reset();

        // Empty mask: straight to UP with nothing released.
        dom_mask = 4'b0000;
        start("mask0_up", 1'b1, 1'b0);
        check_at(1, 4'h0, 1'b0, 1'b1, 1'b0);
        check_at(2, 4'h0, 1'b0, 1'b1, 1'b0);
        start("mask0_dn", 1'b0, 1'b1);
        check_at(1, 4'h0, 1'b0, 1'b0, 1'b0);

        // Maximum gap with config inputs changed after the start; latched values must rule.
        dom_mask   = 4'b0011;
        gap_cycles = 8'd255;
        start("gap255", 1'b1, 1'b0);
        dom_mask   = 4'b1111;
        gap_cycles = 8'd0;
        check_at(1,   4'h1, 1'b1, 1'b0, 1'b0);
        check_at(2,   4'h1, 1'b1, 1'b0, 1'b0);
        check_at(256, 4'h1, 1'b1, 1'b0, 1'b0);
        check_at(257, 4'h3, 1'b0, 1'b1, 1'b0);
        check_at(260, 4'h3, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_testchip_rst_seq

// File: doc/testchip_rst_seq.md
# testchip_rst_seq

Programmable reset sequencer that drives the four per-domain reset-release controls of the testchip clock/reset block (test clock control, DDR IO control, PHY subsystem, PAM3 subsystem). It releases the domains in a fixed order with a programmable gap, asserts them again in reverse order, and reports progress to software. It sits upstream of the clock/reset block in the `noc_clk` domain and replaces direct software writes of the `param_*_reset_n` bits.

## Interface
Parameters:
- `DLY_W`, 8, width of the inter-step gap counter and of `gap_cycles`.

Ports:
- `noc_clk`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `noc_rst`  in  1  synchronous, active-high reset.
- `seq_up_req`  in  1  single-cycle pulse; starts the release (power-up) sequence.
- `seq_dn_req`  in  1  single-cycle pulse; starts the assert (power-down) sequence.
- `dom_mask`  in  4  participating domains: [0] test_clk_ctrl, [1] ddrio_ctrl, [2] phy_ss, [3] pam3_ss. A masked domain stays in reset.
- `gap_cycles`  in  DLY_W  step spacing; consecutive steps are `gap_cycles+1` cycles apart.
- `param_test_clk_ctrl_reset_n`  out  1  domain 0 release, active-low reset.
- `param_ddrio_ctrl_reset_n`  out  1  domain 1 release.
- `param_phy_ss_reset_n`  out  1  domain 2 release.
- `param_pam3_ss_reset_n`  out  1  domain 3 release.
- `seq_busy`  out  1  high while a ramp is in progress.
- `seq_up_done`  out  1  level; all unmasked domains are released.
- `seq_err`  out  1  one-cycle pulse; a request was rejected.

## Operation
- State: a 4-bit `rel` vector (1 = released) drives the outputs directly from flops. The FSM has four states: IDLE (all in reset), RAMP_UP, UP, RAMP_DN.
- `dom_mask` and `gap_cycles` are latched when a ramp starts. Later changes have no effect until the next ramp.
- **IDLE + up_req:** enter RAMP_UP.
  - The lowest-index unmasked domain is released on the same edge.
  - Each further unmasked domain is released in ascending index order, `gap_cycles+1` cycles after the previous one.
  - Masked domains are skipped and consume no gap.
  - On the edge that releases the last unmasked domain, move to UP and set `seq_up_done`.
  - If the mask is all-zero, go IDLE→UP in one edge with `rel` = 0 and `seq_up_done` = 1.
- **UP + dn_req:** enter RAMP_DN.
  - On the same edge, clear `seq_up_done` and assert the highest-index released domain.
  - Continue in descending order with the same spacing.
  - When `rel` reaches 0, go to IDLE.
- **dn_req during RAMP_UP:** abort the ramp.
  - On the next edge, enter RAMP_DN and assert the highest released domain.
  - Continue descending from there.
- **up_req during RAMP_DN:** reject; pulse `seq_err`; the ramp continues.
- **No-op requests:** up_req in UP and dn_req in IDLE change nothing and raise no error. up_req during RAMP_UP is ignored without error.
- **Simultaneous up_req and dn_req:** dn_req wins. `seq_err` pulses only if the current state would reject up_req.
- **Gap counter:** loaded with the latched `gap_cycles` at each step, decrements to 0, and the step fires on the cycle after it reads 0. It never wraps: it holds at 0 when not loaded.

## Timing
- Reset values:
  - all four `param_*_reset_n` = 0
  - `seq_busy` = 0, `seq_up_done` = 0, `seq_err` = 0
  - state = IDLE, gap counter = 0
- `noc_rst` mid-ramp forces the reset values on the next edge. There is no ordered shutdown on reset.
- Request sampled at edge 0 → first output change visible in cycle 1.
- Step k (0-based among unmasked domains) changes in cycle `1 + k*(gap_cycles+1)`.
- `seq_busy` is high in every cycle while state is RAMP_UP or RAMP_DN, and low in the cycle of the final step.
- `seq_err` is registered and pulses in the cycle after the offending request.

## Structure
- Package `testchip_rst_seq_pkg` holds:
  - the FSM state enum (IDLE, RAMP_UP, UP, RAMP_DN)
  - the domain index constants (`DOM_TCLK=0`, `DOM_DDRIO=1`, `DOM_PHY=2`, `DOM_PAM3=3`)
  - `NUM_DOM=4`
- One sub-module, `testchip_rst_gap_cnt`: a loadable down-counter of width `DLY_W` with a `zero` flag.
- Next/previous-domain selection is a priority encoder over `latched_mask & ~rel` (up ramp) or `rel` (down ramp), inline in the top module.

## Test plan
- **Full release:** mask=4'b1111, gap=3, up_req at cycle 0 → domain 0/1/2/3 reset_n rise in cycles 1, 5, 9, 13. `seq_up_done` rises in cycle 13. `seq_busy` is high in cycles 1–12.
- **Masked release:** mask=4'b1010, gap=0, up_req → ddrio rises in cycle 1 and pam3 in cycle 2. Domains 0 and 2 stay 0. Then dn_req → pam3 falls first, ddrio one cycle later, state IDLE.
- **Abort:** mask=4'b1111, gap=5, dn_req at cycle 8 (domains 0 and 1 released) → ddrio falls in cycle 9 and test_clk_ctrl in cycle 15. `seq_up_done` never rises.
- **Request conflicts:** up_req during RAMP_DN → `seq_err` is a one-cycle pulse and the ramp completes unchanged. Simultaneous up_req and dn_req in UP → down ramp, no error.
- **Reset mid-ramp:** `noc_rst` asserted in cycle 6 of a full release → all outputs 0 in cycle 7. A following up_req restarts from domain 0.
- **Edge cases:**
  - mask=0 + up_req → `seq_up_done` = 1 in cycle 1, `seq_busy` never high.
  - gap=255 (`DLY_W`=8) → 256-cycle spacing, with no counter wrap.
